// File: rtl/pipeline_hazard_ctrl_pkg.sv
// rtl/pipeline_hazard_ctrl_pkg.sv - shared types for the pipeline hazard controller
package pipe_pkg;

    localparam int REG_W = 5;

    typedef struct packed {
        logic [REG_W-1:0] dest;
        logic             wb;
        logic             ld;
    } sb_entry_t;

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } ctrl_state_t;

    localparam sb_entry_t SB_INVALID = '0;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// rtl/pipeline_hazard_ctrl_if.sv - ID-stage inputs and pipeline control outputs
interface pipeline_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    import pipe_pkg::*;

    logic             id_valid;
    logic [REG_W-1:0] id_src1;
    logic [REG_W-1:0] id_src2;
    logic             id_two_src;
    logic [REG_W-1:0] id_dest;
    logic             id_wb_en;
    logic             id_mem_r_en;
    logic             exe_br_taken;
    logic             mem_busy;

    logic             pc_freeze;
    logic             ifid_freeze;
    logic             ifid_flush;
    logic             idex_flush;
    logic             pipe_freeze;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output id_valid, id_src1, id_src2, id_two_src, id_dest, id_wb_en, id_mem_r_en,
        output exe_br_taken, mem_busy,
        input  pc_freeze, ifid_freeze, ifid_flush, idex_flush, pipe_freeze, stall_cnt
    );

    modport slave (
        input  id_valid, id_src1, id_src2, id_two_src, id_dest, id_wb_en, id_mem_r_en,
        input  exe_br_taken, mem_busy,
        output pc_freeze, ifid_freeze, ifid_flush, idex_flush, pipe_freeze, stall_cnt
    );

endinterface

// File: rtl/pipeline_hazard_ctrl_cmp.sv
// rtl/pipeline_hazard_ctrl_cmp.sv - one scoreboard entry against the ID sources
module hazard_cmp
    import pipe_pkg::*;
(
    input  sb_entry_t        entry,
    input  logic             ld_only,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_src1,
    input  logic [REG_W-1:0] id_src2,
    input  logic             id_two_src,
    output logic             hit
);

    logic src_match;

    // r0 is hard-wired zero, so a write to it never creates a dependency
    assign src_match = (entry.dest == id_src1) || (id_two_src && (entry.dest == id_src2));
    assign hit = id_valid && entry.wb && (entry.dest != '0) && src_match
                 && (!ld_only || entry.ld);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - RAW stall, branch flush and memory freeze sequencing
module pipeline_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int FORWARD_EN = 1,
    parameter int CNT_W      = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    pipeline_hazard_ctrl_if.slave hz
);

    localparam logic [0:0]       ST_RUN      = RUN;
    localparam logic [0:0]       ST_MEM_WAIT = MEM_WAIT;
    localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [0:0]       state;
    sb_entry_t        sb_ex;
    sb_entry_t        sb_mem;
    logic [CNT_W-1:0] stall_cnt;

    logic ex_hit;
    logic mem_hit;
    logic hazard;
    logic frozen;
    logic pc_freeze;
    logic ifid_freeze;
    logic ifid_flush;
    logic idex_flush;
    logic pipe_freeze;

    hazard_cmp u_cmp_ex (
        .entry      (sb_ex),
        .ld_only    (FORWARD_EN != 0),
        .id_valid   (hz.id_valid),
        .id_src1    (hz.id_src1),
        .id_src2    (hz.id_src2),
        .id_two_src (hz.id_two_src),
        .hit        (ex_hit)
    );

    hazard_cmp u_cmp_mem (
        .entry      (sb_mem),
        .ld_only    (1'b0),
        .id_valid   (hz.id_valid),
        .id_src1    (hz.id_src1),
        .id_src2    (hz.id_src2),
        .id_two_src (hz.id_two_src),
        .hit        (mem_hit)
    );

    // with forwarding only a load still in EX cannot be bypassed in time
    assign hazard = (FORWARD_EN != 0) ? ex_hit : (ex_hit || mem_hit);

    // mem_busy is level-sensitive: MEM_WAIT releases the same cycle it drops
    always_comb begin
        frozen = hz.mem_busy;
        case (state)
            ST_MEM_WAIT: frozen = hz.mem_busy;
            default:     frozen = hz.mem_busy;
        endcase
    end

    always_comb begin
        pc_freeze   = 1'b0;
        ifid_freeze = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        pipe_freeze = 1'b0;
        if (!rst) begin
            if (frozen) begin
                pc_freeze   = 1'b1;
                ifid_freeze = 1'b1;
                pipe_freeze = 1'b1;
            end else if (hz.exe_br_taken) begin
                ifid_flush  = 1'b1;
                idex_flush  = 1'b1;
            end else if (hazard) begin
                pc_freeze   = 1'b1;
                ifid_freeze = 1'b1;
                idex_flush  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_RUN;
            sb_ex     <= SB_INVALID;
            sb_mem    <= SB_INVALID;
            stall_cnt <= '0;
        end else begin
            state <= hz.mem_busy ? ST_MEM_WAIT : ST_RUN;
            if (!pipe_freeze) begin
                sb_mem <= sb_ex;
                sb_ex  <= idex_flush ? SB_INVALID :
                          '{dest: hz.id_dest,
                            wb:   hz.id_wb_en && hz.id_valid,
                            ld:   hz.id_mem_r_en && hz.id_valid};
            end
            if (pc_freeze && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_ONE;
            end
        end
    end

    assign hz.pc_freeze   = pc_freeze;
    assign hz.ifid_freeze = ifid_freeze;
    assign hz.ifid_flush  = ifid_flush;
    assign hz.idex_flush  = idex_flush;
    assign hz.pipe_freeze = pipe_freeze;
    assign hz.stall_cnt   = stall_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - bench for pipeline_hazard_ctrl, forwarding and non-forwarding
module tb_pipeline_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       id_valid = 1'b0;
    logic [4:0] id_src1 = '0;
    logic [4:0] id_src2 = '0;
    logic       id_two_src = 1'b0;
    logic [4:0] id_dest = '0;
    logic       id_wb_en = 1'b0;
    logic       id_mem_r_en = 1'b0;
    logic       exe_br_taken = 1'b0;
    logic       mem_busy = 1'b0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl_if #(.CNT_W(16)) f_if ();
    pipeline_hazard_ctrl_if #(.CNT_W(4))  n_if ();

    assign f_if.id_valid = id_valid;         assign n_if.id_valid = id_valid;
    assign f_if.id_src1 = id_src1;           assign n_if.id_src1 = id_src1;
    assign f_if.id_src2 = id_src2;           assign n_if.id_src2 = id_src2;
    assign f_if.id_two_src = id_two_src;     assign n_if.id_two_src = id_two_src;
    assign f_if.id_dest = id_dest;           assign n_if.id_dest = id_dest;
    assign f_if.id_wb_en = id_wb_en;         assign n_if.id_wb_en = id_wb_en;
    assign f_if.id_mem_r_en = id_mem_r_en;   assign n_if.id_mem_r_en = id_mem_r_en;
    assign f_if.exe_br_taken = exe_br_taken; assign n_if.exe_br_taken = exe_br_taken;
    assign f_if.mem_busy = mem_busy;         assign n_if.mem_busy = mem_busy;

    pipeline_hazard_ctrl #(.FORWARD_EN(1), .CNT_W(16)) u_fwd (
        .clk (clk),
        .rst (rst),
        .hz  (f_if)
    );

    pipeline_hazard_ctrl #(.FORWARD_EN(0), .CNT_W(4)) u_nofwd (
        .clk (clk),
        .rst (rst),
        .hz  (n_if)
    );

    // in-flight instructions as the spec describes them: what sits in EX and MEM
    typedef struct {
        bit       wb;
        bit       ld;
        bit [4:0] dest;
    } inst_t;

    inst_t       m_ex [2];
    inst_t       m_mem[2];
    int unsigned m_cnt[2];
    int          n_vec = 0;
    int          n_err = 0;

    function automatic int unsigned cap(int k);
        return (k == 0) ? 32'd65535 : 32'd15;
    endfunction

    function automatic bit reads(inst_t e);
        return id_valid && e.wb && (e.dest != 0) &&
               ((e.dest == id_src1) || (id_two_src && (e.dest == id_src2)));
    endfunction

    // {pc_freeze, ifid_freeze, ifid_flush, idex_flush, pipe_freeze}
    function automatic logic [4:0] exp_ctrl(int k);
        bit haz;
        if (rst)          return 5'b00000;
        if (mem_busy)     return 5'b11001;
        if (exe_br_taken) return 5'b00110;
        haz = (k == 0) ? (reads(m_ex[0]) && m_ex[0].ld) : (reads(m_ex[1]) || reads(m_mem[1]));
        return haz ? 5'b11010 : 5'b00000;
    endfunction

    function automatic logic [4:0] obs_ctrl(int k);
        if (k == 0)
            return {f_if.pc_freeze, f_if.ifid_freeze, f_if.ifid_flush, f_if.idex_flush, f_if.pipe_freeze};
        return {n_if.pc_freeze, n_if.ifid_freeze, n_if.ifid_flush, n_if.idex_flush, n_if.pipe_freeze};
    endfunction

    function automatic logic [31:0] obs_cnt(int k);
        return (k == 0) ? 32'(f_if.stall_cnt) : 32'(n_if.stall_cnt);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 2; k++) begin
            chk((k == 0) ? "fwd_ctrl" : "nofwd_ctrl", 32'(obs_ctrl(k)), 32'(exp_ctrl(k)));
            chk((k == 0) ? "fwd_cnt" : "nofwd_cnt", obs_cnt(k), m_cnt[k]);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_ex[k]  = '{wb: 0, ld: 0, dest: 0};
            m_mem[k] = '{wb: 0, ld: 0, dest: 0};
            m_cnt[k] = 0;
        end
    endtask

    task automatic model_tick();
        logic [4:0] e;
        if (rst) return;
        for (int k = 0; k < 2; k++) begin
            e = exp_ctrl(k);
            if (e[4] && (m_cnt[k] < cap(k))) m_cnt[k]++;
            if (!e[0]) begin
                m_mem[k] = m_ex[k];
                if (e[1]) m_ex[k] = '{wb: 0, ld: 0, dest: 0};
                else      m_ex[k] = '{wb: id_wb_en && id_valid, ld: id_mem_r_en && id_valid, dest: id_dest};
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        check_all();
        @(posedge clk);
        model_tick();
        #1;
    endtask

    task automatic set_id(input bit v, input bit [4:0] s1, input bit [4:0] s2, input bit two,
                          input bit [4:0] d, input bit wb, input bit ld);
        id_valid = v; id_src1 = s1; id_src2 = s2; id_two_src = two;
        id_dest = d; id_wb_en = wb; id_mem_r_en = ld;
    endtask

    task automatic set_ctl(input bit br, input bit busy);
        exe_br_taken = br;
        mem_busy = busy;
    endtask

    task automatic do_reset();
        set_id(0, 0, 0, 0, 0, 0, 0);
        set_ctl(0, 0);
        rst = 1'b1;
        model_reset();
        #1;
        check_all();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        model_reset();

        // load-use with and without forwarding
        do_reset();
        set_id(1, 0, 0, 0, 5, 1, 1);
        step();
        set_id(1, 5, 1, 1, 6, 1, 0);
        #1;
        chk("t1_pc_freeze", 32'(f_if.pc_freeze), 32'd1);
        chk("t1_idex_flush", 32'(f_if.idex_flush), 32'd1);
        step();
        chk("t1_released", 32'(f_if.pc_freeze), 32'd0);
        chk("t1_cnt", 32'(f_if.stall_cnt), 32'd1);
        step();
        step();

        // ALU producer: no stall with forwarding, EX then MEM stall without
        do_reset();
        set_id(1, 0, 0, 0, 7, 1, 0);
        step();
        set_id(1, 7, 1, 1, 8, 1, 0);
        #1;
        chk("t2_fwd_nostall", 32'(f_if.pc_freeze), 32'd0);
        chk("t2_nofwd_stall", 32'(n_if.pc_freeze), 32'd1);
        repeat (3) step();
        chk("t2_fwd_cnt", 32'(f_if.stall_cnt), 32'd0);
        chk("t2_nofwd_cnt", 32'(n_if.stall_cnt), 32'd2);

        // write to r0 never stalls
        do_reset();
        set_id(1, 0, 0, 0, 0, 1, 1);
        step();
        set_id(1, 0, 0, 1, 9, 1, 0);
        #1;
        chk("t3_r0_fwd", 32'(f_if.pc_freeze), 32'd0);
        chk("t3_r0_nofwd", 32'(n_if.pc_freeze), 32'd0);
        step();

        // taken branch beats a simultaneous load-use
        do_reset();
        set_id(1, 0, 0, 0, 5, 1, 1);
        step();
        set_id(1, 5, 1, 1, 6, 1, 0);
        set_ctl(1, 0);
        #1;
        chk("t4_br_flush", 32'(obs_ctrl(0)), 32'b00110);
        step();
        set_ctl(0, 0);
        #1;
        chk("t4_ex_invalid", 32'(f_if.pc_freeze), 32'd0);
        step();

        // memory busy freezes a pending load-use, which completes afterwards
        do_reset();
        set_id(1, 0, 0, 0, 5, 1, 1);
        step();
        set_id(1, 5, 1, 1, 6, 1, 0);
        set_ctl(0, 1);
        #1;
        chk("t5_pipe_freeze", 32'(f_if.pipe_freeze), 32'd1);
        repeat (3) step();
        set_ctl(0, 0);
        #1;
        chk("t5_stall_after", 32'(obs_ctrl(0)), 32'b11010);
        step();
        step();
        chk("t5_fwd_cnt", 32'(f_if.stall_cnt), 32'd4);

        // asynchronous reset in the middle of a stall
        do_reset();
        set_id(1, 0, 0, 0, 5, 1, 1);
        step();
        set_id(1, 5, 1, 1, 6, 1, 0);
        #1;
        chk("t6_pre_rst", 32'(f_if.pc_freeze), 32'd1);
        rst = 1'b1;
        model_reset();
        #1;
        chk("t6_ctrl_zero", 32'(obs_ctrl(0)), 32'd0);
        chk("t6_cnt_zero", 32'(f_if.stall_cnt), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step();

        // stall counter saturation (4-bit instance)
        do_reset();
        set_ctl(0, 1);
        repeat (20) step();
        set_ctl(0, 0);
        chk("sat_nofwd", 32'(n_if.stall_cnt), 32'd15);
        chk("sat_fwd", 32'(f_if.stall_cnt), 32'd20);

        // random traffic over a small register set to provoke frequent hits
        do_reset();
        for (int i = 0; i < 400; i++) begin
            set_id($urandom_range(0, 4) != 0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)));
            set_ctl($urandom_range(0, 9) == 0, $urandom_range(0, 6) == 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
